// File: rtl/medidor_pwm.sv
// medidor_pwm: measures high time and period of an incoming PWM waveform.
// The input is synchronized (2 flops) and edge-detected (3rd flop); a small
// FSM counts cycles between edges and publishes one width/period pair per
// complete period. A period longer than TIMEOUT declares the signal absent.
module medidor_pwm #(
  parameter int CONT_WIDTH = 16,
  parameter int TIMEOUT    = 2500
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  enable,
  input  logic                  pwm,
  output logic [CONT_WIDTH-1:0] largura_medida,
  output logic [CONT_WIDTH-1:0] periodo_medido,
  output logic                  medida_pronta,
  output logic                  sem_sinal,
  output logic [1:0]            db_estado
);

  typedef enum logic [1:0] {
    ESPERA = 2'b00,
    ALTO   = 2'b01,
    BAIXO  = 2'b10
  } estado_t;

  localparam logic [CONT_WIDTH-1:0] CONT_MAX  = '1;
  localparam logic [CONT_WIDTH-1:0] CONT_ONE  = CONT_WIDTH'(1);
  localparam logic [CONT_WIDTH-1:0] TIMEOUT_C = CONT_WIDTH'(TIMEOUT);

  estado_t                 estado_reg;
  logic [2:0]              sync_reg;
  logic [CONT_WIDTH-1:0]   cnt_alto_reg;
  logic [CONT_WIDTH-1:0]   cnt_periodo_reg;
  logic [CONT_WIDTH-1:0]   larg_cap_reg;

  logic                    s_cur;
  logic                    s_prev;
  logic                    subida;
  logic                    descida;
  logic                    timeout_hit;
  logic [CONT_WIDTH-1:0]   cnt_alto_inc;
  logic [CONT_WIDTH-1:0]   cnt_periodo_inc;

  // sync_reg[1] is the synchronized level, sync_reg[2] its previous value
  assign s_cur   = sync_reg[1];
  assign s_prev  = sync_reg[2];
  assign subida  = s_cur & ~s_prev;
  assign descida = ~s_cur & s_prev;

  // Counters saturate instead of wrapping
  assign cnt_alto_inc    = (cnt_alto_reg == CONT_MAX) ? cnt_alto_reg : cnt_alto_reg + CONT_ONE;
  assign cnt_periodo_inc = (cnt_periodo_reg == CONT_MAX) ? cnt_periodo_reg : cnt_periodo_reg + CONT_ONE;

  // A rising edge in the same cycle takes priority over this (handled in the FSM)
  assign timeout_hit = (cnt_periodo_reg >= TIMEOUT_C);

  assign db_estado = estado_reg;

  // Two-flop synchronizer plus one history flop for edge detection
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      sync_reg <= 3'b000;
    end else begin
      sync_reg <= {sync_reg[1:0], pwm};
    end
  end

  // Measurement FSM: counts, captures the width, publishes on each rising edge after a full period
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      estado_reg      <= ESPERA;
      cnt_alto_reg    <= '0;
      cnt_periodo_reg <= '0;
      larg_cap_reg    <= '0;
      largura_medida  <= '0;
      periodo_medido  <= '0;
      medida_pronta   <= 1'b0;
      sem_sinal       <= 1'b1;
    end else begin
      medida_pronta <= 1'b0;
      if (!enable) begin
        // Idle: restart from scratch, published results are kept
        estado_reg      <= ESPERA;
        cnt_alto_reg    <= '0;
        cnt_periodo_reg <= '0;
      end else begin
        case (estado_reg)
          ESPERA: begin
            // First rising edge only starts a period; nothing is published yet
            if (subida) begin
              cnt_alto_reg    <= CONT_ONE;
              cnt_periodo_reg <= CONT_ONE;
              estado_reg      <= ALTO;
            end else if (timeout_hit) begin
              estado_reg      <= ESPERA;
              sem_sinal       <= 1'b1;
              largura_medida  <= '0;
              periodo_medido  <= '0;
              cnt_alto_reg    <= '0;
              cnt_periodo_reg <= '0;
            end else begin
              cnt_periodo_reg <= cnt_periodo_inc;
            end
          end

          ALTO: begin
            // Covers pwm stuck high as well as a normal long period
            if (timeout_hit) begin
              estado_reg      <= ESPERA;
              sem_sinal       <= 1'b1;
              largura_medida  <= '0;
              periodo_medido  <= '0;
              cnt_alto_reg    <= '0;
              cnt_periodo_reg <= '0;
            end else if (descida) begin
              larg_cap_reg    <= cnt_alto_reg;
              cnt_periodo_reg <= cnt_periodo_inc;
              estado_reg      <= BAIXO;
            end else begin
              cnt_alto_reg    <= cnt_alto_inc;
              cnt_periodo_reg <= cnt_periodo_inc;
            end
          end

          BAIXO: begin
            // Rising edge closes the period: publish and immediately start the next one
            if (subida) begin
              largura_medida  <= larg_cap_reg;
              periodo_medido  <= cnt_periodo_reg;
              medida_pronta   <= 1'b1;
              sem_sinal       <= 1'b0;
              cnt_alto_reg    <= CONT_ONE;
              cnt_periodo_reg <= CONT_ONE;
              estado_reg      <= ALTO;
            end else if (timeout_hit) begin
              estado_reg      <= ESPERA;
              sem_sinal       <= 1'b1;
              largura_medida  <= '0;
              periodo_medido  <= '0;
              cnt_alto_reg    <= '0;
              cnt_periodo_reg <= '0;
            end else begin
              cnt_periodo_reg <= cnt_periodo_inc;
            end
          end

          default: begin
            // Encoding 11 is unused; fall back to a clean wait state
            estado_reg      <= ESPERA;
            cnt_alto_reg    <= '0;
            cnt_periodo_reg <= '0;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_medidor_pwm.sv
// tb_medidor_pwm: randomized and directed PWM stimulus; expected measurements
// are derived from the driven edge times and checked by a separate monitor.
module tb_medidor_pwm;

  localparam int CW = 16;
  localparam int TO = 2500;
  localparam int LAT = 3;

  logic          clock = 1'b0;
  logic          reset = 1'b1;
  logic          enable = 1'b1;
  logic          pwm = 1'b0;
  logic [CW-1:0] largura_medida;
  logic [CW-1:0] periodo_medido;
  logic          medida_pronta;
  logic          sem_sinal;
  logic [1:0]    db_estado;

  medidor_pwm #(.CONT_WIDTH(CW), .TIMEOUT(TO)) dut (
    .clock          (clock),
    .reset          (reset),
    .enable         (enable),
    .pwm            (pwm),
    .largura_medida (largura_medida),
    .periodo_medido (periodo_medido),
    .medida_pronta  (medida_pronta),
    .sem_sinal      (sem_sinal),
    .db_estado      (db_estado)
  );

  always #10 clock = ~clock;

  // number of rising clock edges so far
  int cyc = 0;
  always @(posedge clock) cyc <= cyc + 1;

  typedef struct {
    int w;
    int p;
    int c;
  } exp_t;
  exp_t q[$];

  int n_chk  = 0;
  int n_pass = 0;

  // reference model state: edge times as driven on pwm
  bit armed     = 1'b0;
  int last_rise = 0;
  int last_fall = 0;

  task automatic chk(input bit ok, input string msg);
    n_chk++;
    if (ok) n_pass++;
    else $display("FAIL %s", msg);
  endtask

  // A rise completes a period if the previous rise was seen while measuring
  // and no more than TO cycles have passed; otherwise it only starts one.
  task automatic model_rise(input int t);
    exp_t e;
    if (!enable) return;
    if (armed && (t - last_rise) <= TO) begin
      e.w = last_fall - last_rise;
      e.p = t - last_rise;
      e.c = t + LAT;
      q.push_back(e);
    end
    armed     = 1'b1;
    last_rise = t;
  endtask

  task automatic drive_rise(output int r);
    r   = cyc;
    pwm = 1'b1;
    model_rise(r);
  endtask

  task automatic drive_fall();
    pwm       = 1'b0;
    last_fall = cyc;
  endtask

  task automatic pulse(input int hi, input int lo);
    int r;
    drive_rise(r);
    repeat (hi) @(negedge clock);
    drive_fall();
    repeat (lo) @(negedge clock);
  endtask

  // Signal declared absent exactly TO cycles after the rise is registered
  task automatic timeout_check(input int r, input string tag);
    while (cyc < r + LAT - 1 + TO) @(negedge clock);
    chk(sem_sinal == 1'b0, $sformatf("%s_before sem_sinal=%0b required 0 cyc=%0d", tag, sem_sinal, cyc));
    @(negedge clock);
    chk(sem_sinal == 1'b1 && largura_medida == '0 && periodo_medido == '0 && db_estado == 2'b00,
        $sformatf("%s_at sem=%0b w=%0d p=%0d st=%0d required sem=1 w=0 p=0 st=0 cyc=%0d",
                  tag, sem_sinal, largura_medida, periodo_medido, db_estado, cyc));
  endtask

  // Monitor: every published measurement must match the head of the queue
  always @(negedge clock) begin
    exp_t e;
    if (reset === 1'b1 && medida_pronta === 1'b1) begin
      if (q.size() == 0) begin
        chk(1'b0, $sformatf("pronta_unexpected cyc=%0d w=%0d p=%0d required no pulse",
                            cyc, largura_medida, periodo_medido));
      end else begin
        e = q.pop_front();
        $display("meas cyc=%0d w=%0d p=%0d sem=%0b (exp cyc=%0d w=%0d p=%0d)",
                 cyc, largura_medida, periodo_medido, sem_sinal, e.c, e.w, e.p);
        chk(int'(largura_medida) == e.w && int'(periodo_medido) == e.p && sem_sinal == 1'b0 && cyc == e.c,
            $sformatf("meas got w=%0d p=%0d sem=%0b cyc=%0d required w=%0d p=%0d sem=0 cyc=%0d",
                      largura_medida, periodo_medido, sem_sinal, cyc, e.w, e.p, e.c));
      end
    end
  end

  initial begin
    #(20 * 200000);
    $display("FAIL watchdog expired at cyc=%0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    int r;
    int hi;
    int lo;
    int sel;

    // reset state
    repeat (2) @(negedge clock);
    reset = 1'b0;
    armed = 1'b0;
    #1;
    chk(largura_medida == '0 && periodo_medido == '0 && medida_pronta == 1'b0 && sem_sinal == 1'b1 && db_estado == 2'b00,
        $sformatf("reset_state w=%0d p=%0d pronta=%0b sem=%0b st=%0d required 0 0 0 1 0",
                  largura_medida, periodo_medido, medida_pronta, sem_sinal, db_estado));
    repeat (2) @(negedge clock);
    reset = 1'b1;

    // reset asserted mid-pulse discards the partial period
    repeat (3) pulse(30, 70);
    drive_rise(r);
    repeat (10) @(negedge clock);
    reset = 1'b0;
    armed = 1'b0;
    #1;
    chk(largura_medida == '0 && periodo_medido == '0 && medida_pronta == 1'b0 && sem_sinal == 1'b1 && db_estado == 2'b00,
        $sformatf("reset_mid w=%0d p=%0d pronta=%0b sem=%0b st=%0d required 0 0 0 1 0",
                  largura_medida, periodo_medido, medida_pronta, sem_sinal, db_estado));
    repeat (3) @(negedge clock);
    pwm   = 1'b0;
    reset = 1'b1;
    repeat (20) @(negedge clock);
    repeat (3) pulse(30, 70);

    // steady 50/1250
    repeat (4) pulse(50, 1200);
    chk(sem_sinal == 1'b0, $sformatf("steady_sem sem_sinal=%0b required 0", sem_sinal));

    // waveform changes
    repeat (2) pulse(1000, 250);
    repeat (2) pulse(500, 750);

    // pwm stuck low
    pulse(50, 1200);
    drive_rise(r);
    repeat (50) @(negedge clock);
    drive_fall();
    timeout_check(r, "stuck_low");
    repeat (20) @(negedge clock);

    // pwm stuck high
    repeat (2) pulse(50, 1200);
    drive_rise(r);
    timeout_check(r, "stuck_high");
    drive_fall();
    repeat (20) @(negedge clock);

    // enable dropped mid-high, then re-enabled
    repeat (3) pulse(50, 1200);
    drive_rise(r);
    repeat (20) @(negedge clock);
    enable = 1'b0;
    armed  = 1'b0;
    @(negedge clock);
    chk(db_estado == 2'b00 && largura_medida == CW'(50) && periodo_medido == CW'(1250) && medida_pronta == 1'b0,
        $sformatf("enable_off st=%0d w=%0d p=%0d pronta=%0b required 0 50 1250 0",
                  db_estado, largura_medida, periodo_medido, medida_pronta));
    repeat (30) @(negedge clock);
    drive_fall();
    repeat (100) @(negedge clock);
    enable = 1'b1;
    repeat (50) @(negedge clock);
    repeat (3) pulse(50, 1200);

    // 1-cycle pulses, then periods of exactly TO and TO+1
    repeat (4) pulse(1, 19);
    pulse(10, TO - 10);
    pulse(10, TO - 9);
    repeat (3) pulse(10, 40);

    // randomized waveform, occasionally right at the timeout boundary
    for (int i = 0; i < 40; i++) begin
      hi  = $urandom_range(1, 300);
      sel = $urandom_range(0, 9);
      if (sel == 0)      lo = TO - hi;
      else if (sel == 1) lo = TO - hi + 1;
      else               lo = $urandom_range(1, 300);
      pulse(hi, lo);
    end
    pulse(10, 40);
    repeat (10) @(negedge clock);

    chk(q.size() == 0, $sformatf("pending_expected got %0d left required 0", q.size()));

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
